rom_boot_loader: RTL and testbench



---
 rtl/rom_boot_loader.sv | 196 +++++++++++++++++++
 tb/tb_rom_boot_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_boot_loader.sv
// rom_boot_loader: unpacks 32-bit boot words into timed SRAM byte writes.
// Define ROMLOAD_CHECKSUM_EN to add a 16-bit running checksum of written bytes.
module rom_boot_loader #(
    parameter int                ADDR_W    = 21,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ROM_BYTES = 49152,
    parameter int                WE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              host_reset,
    input  logic [31:0]       host_bootdata,
    input  logic              host_bootdata_req,
    output logic              host_bootdata_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [7:0]        sram_dout,
    output logic              sram_dout_oe,
    output logic              sram_we_n,
    output logic              busy,
`ifdef ROMLOAD_CHECKSUM_EN
    output logic [15:0]       rom_checksum,
    output logic              checksum_valid,
`endif
    output logic              rom_initialised
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0] LAST = CW'(ROM_BYTES);
    localparam int WW = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [WW-1:0] WLAST = WW'(WE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, WRITE, HOLD, ACK, WAITREL, DONE
    } state_t;

    state_t            state, state_d;
    logic [31:0]       word_q, word_d;
    logic [1:0]        idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [WW-1:0]     wcnt_q, wcnt_d;
    logic              fin_q, fin_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        dout_q, dout_d;
    logic              oe_q, oe_d;
    logic              we_n_q, we_n_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              init_q, init_d;
`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0]       csum_q, csum_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            word_q <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
            wcnt_q <= '0;
            fin_q  <= 1'b0;
            addr_q <= BASE_ADDR;
            dout_q <= '0;
            oe_q   <= 1'b0;
            we_n_q <= 1'b1;
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
            init_q <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
            csum_q <= '0;
`endif
        end else begin
            state  <= state_d;
            word_q <= word_d;
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            wcnt_q <= wcnt_d;
            fin_q  <= fin_d;
            addr_q <= addr_d;
            dout_q <= dout_d;
            oe_q   <= oe_d;
            we_n_q <= we_n_d;
            ack_q  <= ack_d;
            busy_q <= busy_d;
            init_q <= init_d;
`ifdef ROMLOAD_CHECKSUM_EN
            csum_q <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        word_d  = word_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cnt_inc = cnt_q + 1'b1;
        wcnt_d  = wcnt_q;
        fin_d   = fin_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        init_d  = init_q;
`ifdef ROMLOAD_CHECKSUM_EN
        csum_d  = csum_q;
`endif

        unique case (state)
            IDLE: begin
                if (host_bootdata_req) begin
                    word_d  = host_bootdata;
                    idx_d   = 2'd0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                wcnt_d  = '0;
                state_d = WRITE;
            end
            WRITE: begin
                if (wcnt_q == WLAST) state_d = HOLD;
                else wcnt_d = wcnt_q + 1'b1;
            end
            HOLD: begin
                cnt_d = cnt_inc;
`ifdef ROMLOAD_CHECKSUM_EN
                csum_d = csum_q + {8'h00, dout_q};
`endif
                if (cnt_inc == LAST) begin
                    fin_d   = 1'b1;
                    state_d = ACK;
                end else if (idx_q == 2'd3) begin
                    state_d = ACK;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = SETUP;
                end
            end
            ACK: begin
                // Always wait for release so a held req is never taken twice.
                if (fin_q) init_d = 1'b1;
                state_d = WAITREL;
            end
            WAITREL: begin
                if (!host_bootdata_req) state_d = fin_q ? DONE : IDLE;
            end
            DONE: begin
                if (host_bootdata_req) state_d = ACK;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state to keep strobes glitch-free.
        if (state_d == SETUP) begin
            addr_d = BASE_ADDR + cnt_d[ADDR_W-1:0];
            unique case (idx_d)
                2'd0: dout_d = word_d[7:0];
                2'd1: dout_d = word_d[15:8];
                2'd2: dout_d = word_d[23:16];
                default: dout_d = word_d[31:24];
            endcase
        end
        oe_d   = (state_d == SETUP) || (state_d == WRITE) || (state_d == HOLD);
        we_n_d = (state_d != WRITE);
        ack_d  = (state_d == ACK);
        busy_d = oe_d || ((state_d == ACK) && (state != DONE));

        if (host_reset) begin
            state_d = IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            wcnt_d  = '0;
            fin_d   = 1'b0;
            addr_d  = BASE_ADDR;
            oe_d    = 1'b0;
            we_n_d  = 1'b1;
            ack_d   = 1'b0;
            busy_d  = 1'b0;
            init_d  = 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
            csum_d  = '0;
`endif
        end
    end

    assign host_bootdata_ack = ack_q;
    assign sram_addr         = addr_q;
    assign sram_dout         = dout_q;
    assign sram_dout_oe      = oe_q;
    assign sram_we_n         = we_n_q;
    assign busy              = busy_q;
    assign rom_initialised   = init_q;
`ifdef ROMLOAD_CHECKSUM_EN
    assign rom_checksum      = csum_q;
    assign checksum_valid    = init_q;
`endif

endmodule

// File: tb/tb_rom_boot_loader.sv
// tb_rom_boot_loader: directed checks of rom_boot_loader with 8- and 6-byte
// ROM images, held requests, post-load requests, host_reset and async reset.
module tb_rom_boot_loader;

    localparam logic [20:0] BASE = 21'h000100;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic        hr_a = 1'b0, req_a = 1'b0;
    logic [31:0] data_a = '0;
    logic        ack_a, oe_a, we_a, busy_a, init_a;
    logic [20:0] addr_a;
    logic [7:0]  dout_a;

    logic        hr_b = 1'b0, req_b = 1'b0;
    logic [31:0] data_b = '0;
    logic        ack_b, oe_b, we_b, busy_b, init_b;
    logic [20:0] addr_b;
    logic [7:0]  dout_b;

`ifdef ROMLOAD_CHECKSUM_EN
    logic [15:0] cs_a, cs_b;
    logic        csv_a, csv_b;
`endif

    rom_boot_loader #(
        .ADDR_W(21), .BASE_ADDR(BASE), .ROM_BYTES(8), .WE_CYCLES(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .host_reset(hr_a),
        .host_bootdata(data_a), .host_bootdata_req(req_a),
        .host_bootdata_ack(ack_a), .sram_addr(addr_a), .sram_dout(dout_a),
        .sram_dout_oe(oe_a), .sram_we_n(we_a), .busy(busy_a),
`ifdef ROMLOAD_CHECKSUM_EN
        .rom_checksum(cs_a), .checksum_valid(csv_a),
`endif
        .rom_initialised(init_a)
    );

    rom_boot_loader #(
        .ADDR_W(21), .BASE_ADDR(BASE), .ROM_BYTES(6), .WE_CYCLES(2)
    ) dut6 (
        .clk(clk), .reset_n(reset_n), .host_reset(hr_b),
        .host_bootdata(data_b), .host_bootdata_req(req_b),
        .host_bootdata_ack(ack_b), .sram_addr(addr_b), .sram_dout(dout_b),
        .sram_dout_oe(oe_b), .sram_we_n(we_b), .busy(busy_b),
`ifdef ROMLOAD_CHECKSUM_EN
        .rom_checksum(cs_b), .checksum_valid(csv_b),
`endif
        .rom_initialised(init_b)
    );

    int checks = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write log: one entry per completed we_n low pulse.
    logic [20:0] wa_a[$], wa_b[$];
    logic [7:0]  wd_a[$], wd_b[$];
    int          wl_a[$], wl_b[$];
    int          lo_a = 0, lo_b = 0, acks_a = 0, acks_b = 0;
    logic        pw_a = 1'b1, pw_b = 1'b1;

    always @(negedge clk) begin
        if (ack_a) acks_a++;
        if (!we_a) lo_a++;
        else if (!pw_a) begin
            wa_a.push_back(addr_a);
            wd_a.push_back(dout_a);
            wl_a.push_back(lo_a);
            lo_a = 0;
        end
        pw_a = we_a;
        if (ack_b) acks_b++;
        if (!we_b) lo_b++;
        else if (!pw_b) begin
            wa_b.push_back(addr_b);
            wd_b.push_back(dout_b);
            wl_b.push_back(lo_b);
            lo_b = 0;
        end
        pw_b = we_b;
    end

    // Cycle 0 is the edge that samples req; returns 0 if no ack within bound.
    task automatic go_a(input logic [31:0] d, input int hold, output int cyc,
                        output logic bsy);
        @(posedge clk);
        #1 data_a = d;
        req_a = 1'b1;
        @(posedge clk);
        cyc = 0;
        bsy = 1'b0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin
                cyc = i;
                bsy = busy_a;
                break;
            end
        end
        repeat (hold) @(negedge clk);
        req_a = 1'b0;
    endtask

    task automatic go_b(input logic [31:0] d, output int cyc);
        @(posedge clk);
        #1 data_b = d;
        req_b = 1'b1;
        @(posedge clk);
        cyc = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ack_b === 1'b1) begin
                cyc = i;
                break;
            end
        end
        req_b = 1'b0;
    endtask

    initial begin
        int c;
        int n0;
        int k0;
        logic bsy;
        logic [31:0] w;

        @(negedge clk);
        chk("rst_addr", 32'(addr_a), 32'(BASE));
        chk("rst_dout", 32'(dout_a), 32'd0);
        chk("rst_oe", 32'(oe_a), 32'd0);
        chk("rst_we_n", 32'(we_a), 32'd1);
        chk("rst_ack", 32'(ack_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_init", 32'(init_a), 32'd0);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // First word, req held 50 cycles beyond ack.
        go_a(32'hDDCCBBAA, 50, c, bsy);
        chk("w1_ack_cycle", 32'(c), 32'd17);
        chk("w1_busy_at_ack", 32'(bsy), 32'd1);
        chk("w1_acks", 32'(acks_a), 32'd1);
        chk("w1_nwrites", 32'(wa_a.size()), 32'd4);
        chk("w1_init", 32'(init_a), 32'd0);
        w = 32'hDDCCBBAA;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w1_addr%0d", i), 32'(wa_a[i]), 32'(BASE) + 32'(i));
            chk($sformatf("w1_data%0d", i), 32'(wd_a[i]), (w >> (8 * i)) & 32'hFF);
            chk($sformatf("w1_we_len%0d", i), 32'(wl_a[i]), 32'd2);
        end
        repeat (3) @(negedge clk);

        // Second word completes the 8-byte image.
        go_a(32'h44332211, 0, c, bsy);
        chk("w2_ack_cycle", 32'(c), 32'd17);
        @(negedge clk);
        chk("w2_init", 32'(init_a), 32'd1);
        chk("w2_acks", 32'(acks_a), 32'd2);
        w = 32'h44332211;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("w2_addr%0d", i), 32'(wa_a[4 + i]), 32'(BASE) + 32'(4 + i));
            chk($sformatf("w2_data%0d", i), 32'(wd_a[4 + i]), (w >> (8 * i)) & 32'hFF);
        end
`ifdef ROMLOAD_CHECKSUM_EN
        chk("w2_checksum", 32'(cs_a), 32'h03B8);
        chk("w2_cs_valid", 32'(csv_a), 32'd1);
`endif
        repeat (3) @(negedge clk);

        // Request after load: immediate ack, no SRAM activity.
        go_a(32'hFFFFFFFF, 3, c, bsy);
        chk("done_ack_cycle", 32'(c), 32'd1);
        repeat (5) @(negedge clk);
        chk("done_acks", 32'(acks_a), 32'd3);
        chk("done_nwrites", 32'(wa_a.size()), 32'd8);
        chk("done_addr", 32'(addr_a), 32'(BASE) + 32'd7);
        chk("done_init", 32'(init_a), 32'd1);

        // host_reset clears the loaded state.
        @(posedge clk);
        #1 hr_a = 1'b1;
        @(posedge clk);
        #1 hr_a = 1'b0;
        @(negedge clk);
        chk("hr_init", 32'(init_a), 32'd0);
        chk("hr_addr", 32'(addr_a), 32'(BASE));

        // host_reset during the write strobe of byte 2.
        n0 = acks_a;
        k0 = wa_a.size();
        @(posedge clk);
        #1 data_a = 32'h87654321;
        req_a = 1'b1;
        @(posedge clk);
        repeat (10) @(negedge clk);
        chk("ab_we_low", 32'(we_a), 32'd0);
        chk("ab_addr", 32'(addr_a), 32'(BASE) + 32'd2);
        hr_a = 1'b1;
        req_a = 1'b0;
        @(negedge clk);
        chk("ab_we_n", 32'(we_a), 32'd1);
        chk("ab_oe", 32'(oe_a), 32'd0);
        chk("ab_busy", 32'(busy_a), 32'd0);
        hr_a = 1'b0;
        repeat (30) @(negedge clk);
        chk("ab_no_ack", 32'(acks_a), 32'(n0));
        chk("ab_nwrites", 32'(wa_a.size() - k0), 32'd3);

        // host_reset and req together: reset wins, req taken next cycle.
        data_a = 32'hA5A55A5A;
        req_a = 1'b1;
        hr_a = 1'b1;
        @(posedge clk);
        #1 hr_a = 1'b0;
        @(posedge clk);
        c = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (ack_a === 1'b1) begin
                c = i;
                break;
            end
        end
        req_a = 1'b0;
        chk("rw_ack_cycle", 32'(c), 32'd17);
        chk("rw_addr0", 32'(wa_a[k0 + 3]), 32'(BASE));
        chk("rw_data0", 32'(wd_a[k0 + 3]), 32'h5A);
        chk("rw_addr3", 32'(wa_a[k0 + 6]), 32'(BASE) + 32'd3);
        chk("rw_data3", 32'(wd_a[k0 + 6]), 32'hA5);

        // Six-byte image: second word writes two bytes and acks early.
        go_b(32'hDDCCBBAA, c);
        chk("b1_ack_cycle", 32'(c), 32'd17);
        @(negedge clk);
        chk("b1_init", 32'(init_b), 32'd0);
        repeat (3) @(negedge clk);
        go_b(32'h44332211, c);
        chk("b2_ack_cycle", 32'(c), 32'd9);
        @(negedge clk);
        chk("b2_init", 32'(init_b), 32'd1);
        repeat (10) @(negedge clk);
        chk("b2_nwrites", 32'(wa_b.size()), 32'd6);
        chk("b2_addr4", 32'(wa_b[4]), 32'(BASE) + 32'd4);
        chk("b2_data4", 32'(wd_b[4]), 32'h11);
        chk("b2_addr5", 32'(wa_b[5]), 32'(BASE) + 32'd5);
        chk("b2_data5", 32'(wd_b[5]), 32'h22);
        chk("b2_acks", 32'(acks_b), 32'd2);
`ifdef ROMLOAD_CHECKSUM_EN
        chk("b2_checksum", 32'(cs_b), 32'h0341);
`endif

        // Asynchronous reset while the strobe is low.
        @(posedge clk);
        #1 data_a = 32'h01020304;
        req_a = 1'b1;
        @(posedge clk);
        repeat (2) @(negedge clk);
        chk("ar_we_low", 32'(we_a), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_we_n", 32'(we_a), 32'd1);
        chk("ar_oe", 32'(oe_a), 32'd0);
        chk("ar_addr", 32'(addr_a), 32'(BASE));
        chk("ar_dout", 32'(dout_a), 32'd0);
        chk("ar_busy", 32'(busy_a), 32'd0);
        chk("ar_ack", 32'(ack_a), 32'd0);
        req_a = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
